// File: rtl/beat_counter.sv
// Heartbeat counter: synchronizes the pulse sensor, debounces beats with a
// refractory dead time, and reports beats per fixed measurement window.
module beat_counter #(
  parameter int WINDOW_CYCLES  = 1_500_000_000,
  parameter int REFRACT_CYCLES = 20_000_000,
  parameter int COUNT_W        = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pulse_in,
  output logic [COUNT_W-1:0] bps,
  output logic               count_valid,
  output logic               beat_pulse,
  output logic               sat
);

  localparam int TIMER_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int REFR_W  = $clog2(REFRACT_CYCLES + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(WINDOW_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = TIMER_W'(0);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);
  localparam logic [REFR_W-1:0]  REFR_LOAD  = REFR_W'(REFRACT_CYCLES);
  localparam logic [REFR_W-1:0]  REFR_ZERO  = REFR_W'(0);
  localparam logic [REFR_W-1:0]  REFR_ONE   = REFR_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ZERO = COUNT_W'(0);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_MAX  = {COUNT_W{1'b1}};

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_REFRACT = 1'b1;

  // Returns {increment_attempted_at_max, next_count}; the count sticks at max.
  function automatic logic [COUNT_W:0] sat_inc(input logic [COUNT_W-1:0] value);
    logic [COUNT_W:0] result;
    if (value == COUNT_MAX) begin
      result = {1'b1, COUNT_MAX};
    end else begin
      result = {1'b0, value + COUNT_ONE};
    end
    return result;
  endfunction

  logic               s1_r;
  logic               s2_r;
  logic               s3_r;
  logic               rise_s;

  logic [0:0]         state_r;
  logic [0:0]         state_nxt_s;
  logic [REFR_W-1:0]  refr_r;
  logic [REFR_W-1:0]  refr_nxt_s;
  logic               accept_s;

  logic [TIMER_W-1:0] timer_r;
  logic               terminal_s;
  logic [COUNT_W-1:0] count_r;
  logic               ovf_r;
  logic [COUNT_W:0]   inc_s;
  logic [COUNT_W-1:0] count_add_s;
  logic               ovf_add_s;

  logic [COUNT_W-1:0] bps_r;
  logic               count_valid_r;
  logic               beat_pulse_r;
  logic               sat_r;

  assign rise_s = s2_r & ~s3_r;

  // Two-flop synchronizer followed by the edge-detect flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= pulse_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Beat FSM next state: accept a rise in IDLE, then sit out the dead time.
  always_comb begin
    state_nxt_s = state_r;
    refr_nxt_s  = refr_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rise_s) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_REFRACT;
          refr_nxt_s  = REFR_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
          refr_nxt_s  = REFR_ZERO;
        end
      end
      ST_REFRACT: begin
        // Rises seen here are dropped; a level still high on exit needs a fresh edge.
        if (refr_r <= REFR_ONE) begin
          state_nxt_s = ST_IDLE;
          refr_nxt_s  = REFR_ZERO;
        end else begin
          state_nxt_s = ST_REFRACT;
          refr_nxt_s  = refr_r - REFR_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        refr_nxt_s  = REFR_ZERO;
      end
    endcase
  end

  // Beat FSM state, refractory counter and the registered beat strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      refr_r       <= REFR_ZERO;
      beat_pulse_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      refr_r       <= refr_nxt_s;
      beat_pulse_r <= accept_s;
    end
  end

  // Running count including any beat accepted this cycle, so a beat on the
  // terminal cycle lands in the closing window.
  always_comb begin
    inc_s      = sat_inc(count_r);
    terminal_s = (timer_r == TIMER_LAST);
    if (accept_s) begin
      count_add_s = inc_s[COUNT_W-1:0];
      ovf_add_s   = ovf_r | inc_s[COUNT_W];
    end else begin
      count_add_s = count_r;
      ovf_add_s   = ovf_r;
    end
  end

  // Window timer, running count, and the per-window result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r       <= TIMER_ZERO;
      count_r       <= COUNT_ZERO;
      ovf_r         <= 1'b0;
      bps_r         <= COUNT_ZERO;
      sat_r         <= 1'b0;
      count_valid_r <= 1'b0;
    end else if (terminal_s) begin
      timer_r       <= TIMER_ZERO;
      count_r       <= COUNT_ZERO;
      ovf_r         <= 1'b0;
      bps_r         <= count_add_s;
      sat_r         <= ovf_add_s;
      count_valid_r <= 1'b1;
    end else begin
      timer_r       <= timer_r + TIMER_ONE;
      count_r       <= count_add_s;
      ovf_r         <= ovf_add_s;
      bps_r         <= bps_r;
      sat_r         <= sat_r;
      count_valid_r <= 1'b0;
    end
  end

  assign bps         = bps_r;
  assign count_valid = count_valid_r;
  assign beat_pulse  = beat_pulse_r;
  assign sat         = sat_r;

endmodule

// File: tb/tb_beat_counter.sv
// Directed bench for beat_counter: a 100-cycle-window instance for most steps
// and a 1000-cycle-window instance for saturation.
module tb_beat_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       pulse_in;
  logic [5:0] bps;
  logic       count_valid;
  logic       beat_pulse;
  logic       sat;

  logic       reset_big;
  logic       pulse_big;
  logic [5:0] bps_big;
  logic       count_valid_big;
  logic       beat_pulse_big;
  logic       sat_big;

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;
  int bcyc   = 0;
  int nbeats = 0;
  int nb0    = 0;

  beat_counter #(.WINDOW_CYCLES(100), .REFRACT_CYCLES(5), .COUNT_W(6)) dut (
    .clk(clk), .reset(reset), .pulse_in(pulse_in), .bps(bps),
    .count_valid(count_valid), .beat_pulse(beat_pulse), .sat(sat)
  );

  beat_counter #(.WINDOW_CYCLES(1000), .REFRACT_CYCLES(5), .COUNT_W(6)) dut_big (
    .clk(clk), .reset(reset_big), .pulse_in(pulse_big), .bps(bps_big),
    .count_valid(count_valid_big), .beat_pulse(beat_pulse_big), .sat(sat_big)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int e_bps, input int e_cv,
                            input int e_bp, input int e_sat);
    check({tag, "_bps"}, 32'(bps), 32'(e_bps));
    check({tag, "_cv"},  32'(count_valid), 32'(e_cv));
    check({tag, "_bp"},  32'(beat_pulse), 32'(e_bp));
    check({tag, "_sat"}, 32'(sat), 32'(e_sat));
  endtask

  // One clock; tcyc/bcyc track the cycle index since each DUT left reset.
  task automatic tick();
    @(posedge clk);
    #1;
    tcyc++;
    bcyc++;
    if (beat_pulse === 1'b1) nbeats++;
  endtask

  task automatic run_to(input int target);
    while (tcyc < target) tick();
  endtask

  initial begin
    reset     = 1'b1;
    pulse_in  = 1'b0;
    reset_big = 1'b1;
    pulse_big = 1'b0;

    // 1: reset with pulse_in toggling, then first count_valid 100 cycles later
    for (int i = 0; i < 3; i++) begin
      pulse_in = ~pulse_in;
      tick();
      check_outs("rst", 0, 0, 0, 0);
    end
    reset    = 1'b0;
    pulse_in = 1'b0;
    tcyc     = 0;
    for (int i = 1; i < 100; i++) begin
      tick();
      check("t1_cv_early", 32'(count_valid), 32'd0);
    end
    tick();
    check_outs("t1_first", 0, 1, 0, 0);

    // 2: ten clean 4-high/4-low pulses, beat strobe 3 cycles after each rise
    for (int p = 0; p < 10; p++) begin
      pulse_in = 1'b1;
      for (int j = 1; j <= 8; j++) begin
        if (j == 5) pulse_in = 1'b0;
        tick();
        check("t2_beat", 32'(beat_pulse), 32'(j == 3));
      end
    end
    run_to(200);
    check_outs("t2_win", 10, 1, 0, 0);
    tick();
    check_outs("t2_hold", 10, 0, 0, 0);

    // 3: 30 edges two cycles apart, only every third accepted
    nb0 = nbeats;
    for (int i = 0; i < 30; i++) begin
      pulse_in = 1'b1;
      tick();
      pulse_in = 1'b0;
      tick();
    end
    run_to(270);
    check("t3_strobes", 32'(nbeats - nb0), 32'd10);
    run_to(300);
    check_outs("t3_win", 10, 1, 0, 0);

    // 5: beat accepted on timer 99 closes into that window; timer 0 into the next
    run_to(397);
    pulse_in = 1'b1;
    tick();
    tick();
    pulse_in = 1'b0;
    tick();
    check_outs("t5_term", 1, 1, 1, 0);
    run_to(498);
    pulse_in = 1'b1;
    tick();
    tick();
    check_outs("t5_zero_close", 0, 1, 0, 0);
    pulse_in = 1'b0;
    tick();
    check("t5_zero_beat", 32'(beat_pulse), 32'd1);
    run_to(600);
    check_outs("t5_next", 1, 1, 0, 0);

    // 6: six beats, reset at timer 50 while refractory, then 3 beats
    run_to(606);
    nb0 = nbeats;
    for (int p = 0; p < 5; p++) begin
      pulse_in = 1'b1;
      for (int j = 1; j <= 8; j++) begin
        if (j == 5) pulse_in = 1'b0;
        tick();
      end
    end
    pulse_in = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    check("t6_strobes", 32'(nbeats - nb0), 32'd6);
    pulse_in = 1'b0;
    reset    = 1'b1;
    tick();
    check_outs("t6_rst", 0, 0, 0, 0);
    reset    = 1'b0;
    tcyc     = 0;
    pulse_in = 1'b1;
    tick();
    tick();
    tick();
    check("t6_idle_beat", 32'(beat_pulse), 32'd1);
    pulse_in = 1'b0;
    run_to(20);
    pulse_in = 1'b1;
    for (int j = 0; j < 3; j++) tick();
    pulse_in = 1'b0;
    run_to(40);
    pulse_in = 1'b1;
    for (int j = 0; j < 3; j++) tick();
    pulse_in = 1'b0;
    run_to(99);
    check("t6_cv_early", 32'(count_valid), 32'd0);
    tick();
    check_outs("t6_win", 3, 1, 0, 0);

    // 4: 1000-cycle window, 70 beats saturate at 63, then 5 beats clear sat
    check("t4_rst_bps", 32'(bps_big), 32'd0);
    reset_big = 1'b0;
    bcyc      = 0;
    for (int i = 0; i < 70; i++) begin
      pulse_big = 1'b1;
      for (int j = 1; j <= 12; j++) begin
        if (j == 7) pulse_big = 1'b0;
        tick();
      end
    end
    while (bcyc < 999) tick();
    check("t4_cv_early", 32'(count_valid_big), 32'd0);
    tick();
    check("t4_sat_bps", 32'(bps_big), 32'd63);
    check("t4_sat_sat", 32'(sat_big), 32'd1);
    check("t4_sat_cv",  32'(count_valid_big), 32'd1);
    for (int i = 0; i < 5; i++) begin
      pulse_big = 1'b1;
      for (int j = 1; j <= 12; j++) begin
        if (j == 7) pulse_big = 1'b0;
        tick();
      end
    end
    check("t4_hold_bps", 32'(bps_big), 32'd63);
    while (bcyc < 2000) tick();
    check("t4_next_bps", 32'(bps_big), 32'd5);
    check("t4_next_sat", 32'(sat_big), 32'd0);
    check("t4_next_cv",  32'(count_valid_big), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
